// File: rtl/combo_round_ctrl.sv
// Round sequencer for the combo/climax scoring datapath: beat grid, hit judging,
// miss tracking and win/lose decision. All outputs are registered.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start, phase held at 0
// READY  | countdown beats, hits ignored
// PLAY   | scored beats, one verdict per beat
// CLIMAX | scored like PLAY, a miss drops back to PLAY
// RESULT | round over, won/beat_cnt/miss_cnt held until next start
module combo_round_ctrl #(
   parameter int unsigned BEAT_DIV    = 50,
   parameter int unsigned WINDOW      = 5,
   parameter int unsigned READY_BEATS = 4,
   parameter int unsigned ROUND_BEATS = 16,
   parameter int unsigned MAX_MISS    = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       hit_i,
   input  logic       climax_in_i,
   output logic       niceplay_o,
   output logic       combo_clr_o,
   output logic       beat_o,
   output logic [2:0] state_o,
   output logic [7:0] beat_cnt_o,
   output logic [2:0] miss_cnt_o,
   output logic       done_o,
   output logic       won_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READY  = 3'd1,
      S_PLAY   = 3'd2,
      S_CLIMAX = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   localparam logic [7:0] PH_LAST  = 8'(BEAT_DIV - 1);
   localparam logic [7:0] WIN      = 8'(WINDOW);
   localparam logic [3:0] RDY_LAST = 4'(READY_BEATS - 1);
   localparam logic [7:0] RB       = 8'(ROUND_BEATS);
   localparam logic [2:0] MM       = 3'(MAX_MISS);

   state_t     state_q, state_d;
   logic [7:0] phase_q, phase_d;
   logic [3:0] ready_q, ready_d;
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic [2:0] miss_cnt_q, miss_cnt_d;
   logic       scored_q, scored_d;
   logic       won_q, won_d;
   logic       niceplay_q, niceplay_d;
   logic       combo_clr_q, combo_clr_d;
   logic       beat_q, beat_d;
   logic       done_q, done_d;

   logic eob;
   logic in_play;
   logic nice;
   logic miss;

   assign eob     = (phase_q == PH_LAST);
   assign in_play = (state_q == S_PLAY) || (state_q == S_CLIMAX);
   // A hit on the EOB cycle falls outside the window, so it and the EOB share one verdict.
   assign nice    = in_play && hit_i && !scored_q && (phase_q < WIN);
   assign miss    = in_play && !scored_q && (eob || (hit_i && (phase_q >= WIN)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         phase_q     <= 8'd0;
         ready_q     <= 4'd0;
         beat_cnt_q  <= 8'd0;
         miss_cnt_q  <= 3'd0;
         scored_q    <= 1'b0;
         won_q       <= 1'b0;
         niceplay_q  <= 1'b0;
         combo_clr_q <= 1'b0;
         beat_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         ready_q     <= ready_d;
         beat_cnt_q  <= beat_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         scored_q    <= scored_d;
         won_q       <= won_d;
         niceplay_q  <= niceplay_d;
         combo_clr_q <= combo_clr_d;
         beat_q      <= beat_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      ready_d    = ready_q;
      beat_cnt_d = beat_cnt_q;
      miss_cnt_d = miss_cnt_q;
      scored_d   = scored_q;
      won_d      = won_q;
      case (state_q)
         S_IDLE, S_RESULT: begin
            if (start_i) begin
               state_d    = S_READY;
               phase_d    = 8'd0;
               ready_d    = 4'd0;
               beat_cnt_d = 8'd0;
               miss_cnt_d = 3'd0;
               scored_d   = 1'b0;
               won_d      = 1'b0;
            end
         end
         S_READY: begin
            phase_d = eob ? 8'd0 : phase_q + 8'd1;
            if (eob) begin
               if (ready_q == RDY_LAST) begin
                  state_d    = S_PLAY;
                  ready_d    = 4'd0;
                  beat_cnt_d = 8'd0;
                  miss_cnt_d = 3'd0;
                  scored_d   = 1'b0;
               end else begin
                  ready_d = ready_q + 4'd1;
               end
            end
         end
         S_PLAY, S_CLIMAX: begin
            phase_d  = eob ? 8'd0 : phase_q + 8'd1;
            scored_d = eob ? 1'b0 : (scored_q | nice | miss);
            if (eob) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
            if (miss && (miss_cnt_q != 3'd7)) begin
               miss_cnt_d = miss_cnt_q + 3'd1;
            end
            // Miss limit is checked first so a simultaneous final beat still loses.
            if (miss_cnt_d >= MM) begin
               state_d = S_RESULT;
               phase_d = 8'd0;
               won_d   = 1'b0;
            end else if (beat_cnt_d >= RB) begin
               state_d = S_RESULT;
               phase_d = 8'd0;
               won_d   = 1'b1;
            end else if (state_q == S_PLAY) begin
               if (climax_in_i) begin
                  state_d = S_CLIMAX;
               end
            end else if (miss) begin
               state_d = S_PLAY;
            end
         end
         default: begin
            state_d = S_IDLE;
            phase_d = 8'd0;
         end
      endcase
   end

   always_comb begin
      niceplay_d  = nice;
      combo_clr_d = miss || (start_i && ((state_q == S_IDLE) || (state_q == S_RESULT)));
      beat_d      = (phase_d == 8'd0) &&
                    ((state_d == S_READY) || (state_d == S_PLAY) || (state_d == S_CLIMAX));
      done_d      = (state_d == S_RESULT);
   end

   assign niceplay_o  = niceplay_q;
   assign combo_clr_o = combo_clr_q;
   assign beat_o      = beat_q;
   assign state_o     = state_q;
   assign beat_cnt_o  = beat_cnt_q;
   assign miss_cnt_o  = miss_cnt_q;
   assign done_o      = done_q;
   assign won_o       = won_q;

endmodule

// File: tb/tb_combo_round_ctrl.sv
// Bench for combo_round_ctrl: scripted scenarios plus random rounds checked against
// a per-beat verdict model (first hit of a beat decides, no hit means an EOB miss).
module tb_combo_round_ctrl;

   localparam int BD  = 10;
   localparam int WIN = 3;
   localparam int RDY = 2;
   localparam int RB  = 4;
   localparam int MM  = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_READY  = 3'd1;
   localparam logic [2:0] ST_PLAY   = 3'd2;
   localparam logic [2:0] ST_CLIMAX = 3'd3;
   localparam logic [2:0] ST_RESULT = 3'd4;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic       hit_i;
   logic       climax_in_i;
   logic       niceplay_o;
   logic       combo_clr_o;
   logic       beat_o;
   logic [2:0] state_o;
   logic [7:0] beat_cnt_o;
   logic [2:0] miss_cnt_o;
   logic       done_o;
   logic       won_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [BD-1:0] pat [RB];

   combo_round_ctrl #(
      .BEAT_DIV(BD), .WINDOW(WIN), .READY_BEATS(RDY), .ROUND_BEATS(RB), .MAX_MISS(MM)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hit_i(hit_i),
      .climax_in_i(climax_in_i), .niceplay_o(niceplay_o), .combo_clr_o(combo_clr_o),
      .beat_o(beat_o), .state_o(state_o), .beat_cnt_o(beat_cnt_o),
      .miss_cnt_o(miss_cnt_o), .done_o(done_o), .won_o(won_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      int bad;
      rst_i = 1'b1; start_i = 1'b0; hit_i = 1'b0; climax_in_i = 1'b0;
      repeat (3) step();
      n_tests++;
      if ({state_o, niceplay_o, combo_clr_o, beat_o, beat_cnt_o, miss_cnt_o, done_o, won_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d nice=%b clr=%b beat=%b bc=%0d miss=%0d done=%b won=%b expected all 0",
                  state_o, niceplay_o, combo_clr_o, beat_o, beat_cnt_o, miss_cnt_o, done_o, won_o);
      end
      rst_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         hit_i = 1'($urandom_range(0, 1));
         step();
         if (beat_o !== 1'b0 || state_o !== ST_IDLE || niceplay_o !== 1'b0 || combo_clr_o !== 1'b0) bad++;
      end
      hit_i = 1'b0;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL idle_quiet: %0d bad cycles, expected 0", bad);
      end
   endtask

   // From IDLE or RESULT: pulse start, walk through READY, arrive at PLAY phase 0.
   task automatic start_round(input string tag);
      int bad;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      n_tests++;
      if ({state_o, combo_clr_o, beat_o, done_o, won_o, beat_cnt_o, miss_cnt_o} !==
          {ST_READY, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0}) begin
         n_fail++;
         $display("FAIL %s_start: state=%0d clr=%b beat=%b done=%b won=%b bc=%0d miss=%0d expected 1/1/1/0/0/0/0",
                  tag, state_o, combo_clr_o, beat_o, done_o, won_o, beat_cnt_o, miss_cnt_o);
      end
      bad = 0;
      for (int c = 1; c < RDY * BD; c++) begin
         hit_i = ($urandom_range(0, 3) == 0);
         start_i = 1'($urandom_range(0, 1));
         step();
         if ({state_o, niceplay_o, combo_clr_o, beat_o} !== {ST_READY, 1'b0, 1'b0, (c % BD == 0)}) bad++;
      end
      hit_i = 1'b0;
      start_i = 1'b0;
      step();
      n_tests++;
      if (bad != 0 || state_o !== ST_PLAY || beat_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready: bad=%0d state=%0d beat=%b expected 0/2/1", tag, bad, state_o, beat_o);
      end
   endtask

   // Drives pat[] into PLAY (climax_in low) and checks every cycle against the verdict model.
   task automatic run_play(input string tag);
      int          m_miss;
      int          vp;
      bit          vnice, lost, won_end, ended;
      logic [7:0]  e_bc;
      logic [2:0]  e_st;
      logic [18:0] obs, exp_v;
      m_miss = 0;
      ended  = 0;
      for (int b = 0; b < RB; b++) begin
         if (!ended) begin
            vp = BD - 1;
            for (int p = BD - 1; p >= 0; p--) if (pat[b][p]) vp = p;
            vnice = (pat[b] != '0) && (vp < WIN);
            for (int p = 0; p < BD; p++) begin
               if (!ended) begin
                  hit_i = pat[b][p];
                  step();
                  hit_i = 1'b0;
                  lost = 0;
                  if (p == vp && !vnice) begin
                     m_miss++;
                     lost = (m_miss >= MM);
                  end
                  won_end = !lost && (p == BD - 1) && (b == RB - 1);
                  e_bc    = 8'(b + ((p == BD - 1) ? 1 : 0));
                  e_st    = (lost || won_end) ? ST_RESULT : ST_PLAY;
                  exp_v   = {(p == vp && vnice), (p == vp && !vnice), (!lost && !won_end && p == BD - 1),
                             e_st, e_bc, 3'(m_miss), (lost || won_end), won_end};
                  obs     = {niceplay_o, combo_clr_o, beat_o, state_o, beat_cnt_o, miss_cnt_o, done_o, won_o};
                  n_tests++;
                  if (obs !== exp_v) begin
                     n_fail++;
                     $display("FAIL %s b%0d p%0d: nice,clr,beat,state,bc,miss,done,won got %b,%b,%b,%0d,%0d,%0d,%b,%b expected %b,%b,%b,%0d,%0d,%0d,%b,%b",
                              tag, b, p, obs[18], obs[17], obs[16], obs[15:13], obs[12:5], obs[4:2], obs[1], obs[0],
                              exp_v[18], exp_v[17], exp_v[16], exp_v[15:13], exp_v[12:5], exp_v[4:2], exp_v[1], exp_v[0]);
                  end
                  ended = lost || won_end;
               end
            end
         end
      end
   endtask

   task automatic test_nice_round();
      for (int b = 0; b < RB; b++) pat[b] = BD'(1) << 1;
      start_round("nice");
      run_play("nice");
   endtask

   task automatic test_restart_window();
      for (int i = 0; i < 3; i++) begin
         hit_i = 1'b1;
         step();
      end
      hit_i = 1'b0;
      n_tests++;
      if ({state_o, done_o, won_o, beat_cnt_o, miss_cnt_o, niceplay_o, combo_clr_o, beat_o} !==
          {ST_RESULT, 1'b1, 1'b1, 8'd4, 3'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL result_hold: state=%0d done=%b won=%b bc=%0d miss=%0d expected 4/1/1/4/0",
                  state_o, done_o, won_o, beat_cnt_o, miss_cnt_o);
      end
      pat[0] = '0; pat[0][1] = 1'b1; pat[0][2] = 1'b1;
      pat[1] = '0; pat[1][5] = 1'b1; pat[1][7] = 1'b1;
      pat[2] = '0; pat[2][0] = 1'b1;
      pat[3] = '0; pat[3][2] = 1'b1;
      start_round("restart");
      run_play("window");
   endtask

   task automatic test_miss_loss();
      for (int b = 0; b < RB; b++) pat[b] = '0;
      start_round("loss");
      run_play("loss");
   endtask

   task automatic test_climax();
      int bad;
      start_round("climax");
      climax_in_i = 1'b1;
      step();
      climax_in_i = 1'b0;
      n_tests++;
      if ({state_o, beat_cnt_o, miss_cnt_o} !== {ST_CLIMAX, 8'd0, 3'd0}) begin
         n_fail++;
         $display("FAIL climax_enter: state=%0d bc=%0d miss=%0d expected 3/0/0", state_o, beat_cnt_o, miss_cnt_o);
      end
      bad = 0;
      for (int p = 1; p < BD - 1; p++) begin
         climax_in_i = 1'($urandom_range(0, 1));
         step();
         if (state_o !== ST_CLIMAX || niceplay_o !== 1'b0 || combo_clr_o !== 1'b0) bad++;
      end
      climax_in_i = 1'b0;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL climax_hold: %0d bad cycles, expected 0", bad);
      end
      hit_i = 1'b1;
      step();
      hit_i = 1'b0;
      n_tests++;
      if ({state_o, combo_clr_o, niceplay_o, miss_cnt_o, beat_cnt_o, beat_o} !==
          {ST_PLAY, 1'b1, 1'b0, 3'd1, 8'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL climax_eob_hit: state=%0d clr=%b nice=%b miss=%0d bc=%0d beat=%b expected 2/1/0/1/1/1",
                  state_o, combo_clr_o, niceplay_o, miss_cnt_o, beat_cnt_o, beat_o);
      end
      step();
      n_tests++;
      if ({state_o, combo_clr_o, miss_cnt_o} !== {ST_PLAY, 1'b0, 3'd1}) begin
         n_fail++;
         $display("FAIL climax_single_miss: state=%0d clr=%b miss=%0d expected 2/0/1", state_o, combo_clr_o, miss_cnt_o);
      end
   endtask

   task automatic test_reset_mid_play();
      rst_i = 1'b1;
      hit_i = 1'b1;
      step();
      rst_i = 1'b0;
      hit_i = 1'b0;
      n_tests++;
      if ({state_o, niceplay_o, combo_clr_o, beat_o, beat_cnt_o, miss_cnt_o, done_o, won_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: state=%0d nice=%b clr=%b beat=%b bc=%0d miss=%0d expected all 0",
                  state_o, niceplay_o, combo_clr_o, beat_o, beat_cnt_o, miss_cnt_o);
      end
      step();
      n_tests++;
      if ({state_o, combo_clr_o, beat_o, beat_cnt_o, miss_cnt_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_after: state=%0d clr=%b beat=%b bc=%0d miss=%0d expected all 0",
                  state_o, combo_clr_o, beat_o, beat_cnt_o, miss_cnt_o);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         for (int b = 0; b < RB; b++) begin
            pat[b] = '0;
            case ($urandom_range(0, 3))
               1: pat[b][$urandom_range(0, BD - 1)] = 1'b1;
               2: begin
                  pat[b][$urandom_range(0, WIN - 1)] = 1'b1;
                  pat[b][$urandom_range(0, BD - 1)] = 1'b1;
               end
               3: pat[b][$urandom_range(0, WIN - 1)] = 1'b1;
               default: pat[b] = '0;
            endcase
         end
         start_round("rand");
         run_play("rand");
         repeat ($urandom_range(0, 3)) begin
            hit_i = 1'($urandom_range(0, 1));
            step();
         end
         hit_i = 1'b0;
      end
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; hit_i = 1'b0; climax_in_i = 1'b0;
      test_reset();
      test_nice_round();
      test_restart_window();
      test_miss_loss();
      test_climax();
      test_reset_mid_play();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
